// File: rtl/systolic_sched.sv
// systolic_sched: tile scheduler for an N x N systolic array computing an
// M x M by M x M product. It streams A/B operand reads tile by tile in
// row-major order with no gaps, and generates the skewed per-PE end-of-tile
// pulses. It also reports tile and job completion.
// Optional feature: define SCHED_PERF_CNT_EN to enable the busy-cycle
// counter on perf_cycles. Otherwise perf_cycles is tied to 0.
module systolic_sched #(
  parameter  int unsigned N      = 4,
  parameter  int unsigned M      = 8,
  parameter  int unsigned RD_LAT = 1,
  localparam int unsigned MT     = M / N,
  localparam int unsigned T      = MT * MT,
  localparam int unsigned AW     = ((M * M / N) > 1) ? $clog2(M * M / N) : 1,
  localparam int unsigned IW     = $clog2(T) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            rd_en_A,
  output logic [AW-1:0]   rd_addr_A,
  output logic            rd_en_B,
  output logic [AW-1:0]   rd_addr_B,
  output logic [N*N-1:0]  init_pe,
  output logic            tile_done,
  output logic [IW-1:0]   tile_idx,
  output logic [31:0]     perf_cycles
);

  localparam int unsigned KW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned TW = (MT > 1) ? $clog2(MT) : 1;
  localparam int unsigned SD = RD_LAT + 2 * (N - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [KW-1:0]   r_k, w_k_nxt;
  logic [TW-1:0]   r_tj, w_tj_nxt;
  logic [TW-1:0]   r_ti, w_ti_nxt;
  logic            w_rd_nxt, w_done_nxt, w_clr, w_last_nxt, w_busy_nxt;
  logic            w_k_end, w_tj_end, w_ti_end;
  logic            r_rd, r_last, r_busy, r_done;
  logic [AW-1:0]   r_addr_A, r_addr_B;
  logic [SD-1:0]   r_skew;
  logic [IW-1:0]   r_tile_idx;
  logic            w_tile_done;

  assign w_k_end     = (r_k  == KW'(M - 1));
  assign w_tj_end    = (r_tj == TW'(MT - 1));
  assign w_ti_end    = (r_ti == TW'(MT - 1));
  assign w_tile_done = r_skew[SD-1];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, loop-counter advance and strobes for the coming cycle
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_tj_nxt    = r_tj;
    w_ti_nxt    = r_ti;
    w_rd_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_STREAM;
          w_k_nxt     = '0;
          w_tj_nxt    = '0;
          w_ti_nxt    = '0;
          w_rd_nxt    = 1'b1;
          w_clr       = 1'b1;
        end
      end
      S_STREAM: begin
        if (w_k_end && w_tj_end && w_ti_end) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_rd_nxt = 1'b1;
          if (w_k_end) begin
            w_k_nxt = '0;
            if (w_tj_end) begin
              w_tj_nxt = '0;
              w_ti_nxt = r_ti + TW'(1);
            end else begin
              w_tj_nxt = r_tj + TW'(1);
            end
          end else begin
            w_k_nxt = r_k + KW'(1);
          end
        end
      end
      S_DRAIN: begin
        // Leave as the final tile_done lands so done lines up with tile_idx == T
        if ((w_tile_done && (r_tile_idx == IW'(T - 1))) || (r_tile_idx == IW'(T))) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_last_nxt = w_rd_nxt && (w_k_nxt == KW'(M - 1));
  assign w_busy_nxt = (w_state_nxt != S_IDLE);

  // Counters and registered read/handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k      <= '0;
      r_tj     <= '0;
      r_ti     <= '0;
      r_rd     <= 1'b0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_addr_A <= '0;
      r_addr_B <= '0;
    end else begin
      r_k      <= w_k_nxt;
      r_tj     <= w_tj_nxt;
      r_ti     <= w_ti_nxt;
      r_rd     <= w_rd_nxt;
      r_last   <= w_last_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_addr_A <= AW'(w_ti_nxt) * AW'(M) + AW'(w_k_nxt);
      r_addr_B <= AW'(w_tj_nxt) * AW'(M) + AW'(w_k_nxt);
    end
  end

  // Skew line: bit i carries the last-read marker delayed by i+1 cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_skew <= '0;
    else        r_skew <= (r_skew << 1) | SD'(r_last);
  end

  // PE[x][y] taps the marker delayed by RD_LAT + x + y cycles
  for (genvar x = 0; x < N; x++) begin : g_row
    for (genvar y = 0; y < N; y++) begin : g_col
      assign init_pe[x*N+y] = r_skew[RD_LAT+x+y-1];
    end
  end

  // Completed-tile count for the current job
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_tile_idx <= '0;
    else if (w_clr)       r_tile_idx <= '0;
    else if (w_tile_done) r_tile_idx <= r_tile_idx + IW'(1);
  end

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] r_perf;

  // Saturating busy-cycle counter, cleared at job start, held in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_perf <= '0;
    else if (w_clr)                      r_perf <= '0;
    else if (r_busy && (r_perf != '1))   r_perf <= r_perf + 32'd1;
  end

  assign perf_cycles = r_perf;
`else
  assign perf_cycles = 32'd0;
`endif

  assign busy      = r_busy;
  assign done      = r_done;
  assign rd_en_A   = r_rd;
  assign rd_en_B   = r_rd;
  assign rd_addr_A = r_addr_A;
  assign rd_addr_B = r_addr_B;
  assign tile_done = w_tile_done;
  assign tile_idx  = r_tile_idx;

endmodule

// File: tb/tb_systolic_sched.sv
// Scoreboard bench for systolic_sched: stimulus pushes expected events,
// negedge monitors pop and compare them. Covers the default build plus an
// N=2, M=4, RD_LAT=2 instance.
module tb_systolic_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, start2;

  logic        busy, done, rd_en_A, rd_en_B, tile_done;
  logic [3:0]  rd_addr_A, rd_addr_B;
  logic [15:0] init_pe;
  logic [2:0]  tile_idx;
  logic [31:0] perf_cycles;

  logic        busy2, done2, rd_en_A2, rd_en_B2, tile_done2;
  logic [2:0]  rd_addr_A2, rd_addr_B2;
  logic [3:0]  init_pe2;
  logic [2:0]  tile_idx2;
  logic [31:0] perf_cycles2;

`ifdef SCHED_PERF_CNT_EN
  localparam int PERF_EXP = 40;
`else
  localparam int PERF_EXP = 0;
`endif

  systolic_sched #(.N(4), .M(8), .RD_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en_A(rd_en_A), .rd_addr_A(rd_addr_A), .rd_en_B(rd_en_B), .rd_addr_B(rd_addr_B),
    .init_pe(init_pe), .tile_done(tile_done), .tile_idx(tile_idx), .perf_cycles(perf_cycles)
  );

  systolic_sched #(.N(2), .M(4), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .rd_en_A(rd_en_A2), .rd_addr_A(rd_addr_A2), .rd_en_B(rd_en_B2), .rd_addr_B(rd_addr_B2),
    .init_pe(init_pe2), .tile_done(tile_done2), .tile_idx(tile_idx2), .perf_cycles(perf_cycles2)
  );

  typedef struct {
    int cyc;
    int a;
    int b;
  } rd_t;

  rd_t q_rd[$];
  rd_t q_rd2[$];
  int  q_pe0[$], q_pe5[$], q_td[$], q_done[$];
  int  q_td2[$], q_done2[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  base;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d: got an event expected none", name, cyc);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask

  function automatic int pending();
    return q_rd.size() + q_rd2.size() + q_pe0.size() + q_pe5.size() + q_td.size() +
           q_done.size() + q_td2.size() + q_done2.size();
  endfunction

  // Default job (N=4, M=8, RD_LAT=1); events after cycle lim are not expected
  task automatic push_job1(input int b, input int lim);
    int  pe0[4];
    int  pe5[4];
    int  td[4];
    rd_t e;
    pe0 = '{9, 17, 25, 33};
    pe5 = '{11, 19, 27, 35};
    td  = '{15, 23, 31, 39};
    for (int c = 1; c <= 32; c++) begin
      if (c <= lim) begin
        e.cyc = b + c;
        e.a   = ((c - 1) / 16) * 8 + (c - 1) % 8;
        e.b   = (((c - 1) / 8) % 2) * 8 + (c - 1) % 8;
        q_rd.push_back(e);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (pe0[i] <= lim) q_pe0.push_back(b + pe0[i]);
      if (pe5[i] <= lim) q_pe5.push_back(b + pe5[i]);
      if (td[i]  <= lim) q_td.push_back(b + td[i]);
    end
    if (40 <= lim) q_done.push_back(b + 40);
  endtask

  // Small job (N=2, M=4, RD_LAT=2): tile_done at (t+1)*4 + 2 + 2, done at 16 + 4 + 1
  task automatic push_job2(input int b);
    int  td[4];
    rd_t e;
    td = '{8, 12, 16, 20};
    for (int c = 1; c <= 16; c++) begin
      e.cyc = b + c;
      e.a   = ((c - 1) / 8) * 4 + (c - 1) % 4;
      e.b   = (((c - 1) / 4) % 2) * 4 + (c - 1) % 4;
      q_rd2.push_back(e);
    end
    for (int i = 0; i < 4; i++) q_td2.push_back(b + td[i]);
    q_done2.push_back(b + 21);
  endtask

  // Monitor for the default instance
  always @(negedge clk) begin
    rd_t e;
    if (rd_en_A || rd_en_B) begin
      chk("rd_en_B_eq_A", rd_en_B, rd_en_A);
      if (q_rd.size() == 0) unexpected("read");
      else begin
        e = q_rd.pop_front();
        chk("rd_cycle", cyc, e.cyc);
        chk("rd_addr_A", rd_addr_A, e.a);
        chk("rd_addr_B", rd_addr_B, e.b);
      end
    end
    if (init_pe[0]) begin
      if (q_pe0.size() == 0) unexpected("init_pe0");
      else chk("init_pe0_cycle", cyc, q_pe0.pop_front());
    end
    if (init_pe[5]) begin
      if (q_pe5.size() == 0) unexpected("init_pe5");
      else chk("init_pe5_cycle", cyc, q_pe5.pop_front());
    end
    if (tile_done) begin
      chk("init_pe15_with_tile_done", init_pe[15], 1);
      if (q_td.size() == 0) unexpected("tile_done");
      else chk("tile_done_cycle", cyc, q_td.pop_front());
    end
    if (done) begin
      if (q_done.size() == 0) unexpected("done");
      else begin
        chk("done_cycle", cyc, q_done.pop_front());
        chk("done_tile_idx", tile_idx, 4);
        chk("done_busy", busy, 1);
      end
    end
  end

  // Monitor for the N=2 instance
  always @(negedge clk) begin
    rd_t e;
    if (rd_en_A2 || rd_en_B2) begin
      chk("rd2_en_B_eq_A", rd_en_B2, rd_en_A2);
      if (q_rd2.size() == 0) unexpected("read2");
      else begin
        e = q_rd2.pop_front();
        chk("rd2_cycle", cyc, e.cyc);
        chk("rd2_addr_A", rd_addr_A2, e.a);
        chk("rd2_addr_B", rd_addr_B2, e.b);
      end
    end
    if (tile_done2) begin
      if (q_td2.size() == 0) unexpected("tile_done2");
      else chk("tile_done2_cycle", cyc, q_td2.pop_front());
    end
    if (done2) begin
      if (q_done2.size() == 0) unexpected("done2");
      else begin
        chk("done2_cycle", cyc, q_done2.pop_front());
        chk("done2_tile_idx", tile_idx2, 4);
      end
    end
  end

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while ((pending() != 0) && (n < budget)) begin
      tick();
      n++;
    end
    chk("events_outstanding", pending(), 0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en_A"}, rd_en_A, 0);
    chk({tag, "_rd_en_B"}, rd_en_B, 0);
    chk({tag, "_rd_addr_A"}, rd_addr_A, 0);
    chk({tag, "_rd_addr_B"}, rd_addr_B, 0);
    chk({tag, "_init_pe"}, init_pe, 0);
    chk({tag, "_tile_done"}, tile_done, 0);
    chk({tag, "_tile_idx"}, tile_idx, 0);
    chk({tag, "_perf"}, perf_cycles, 0);
  endtask

  initial begin
    rst_n  = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    #2;
    rst_n = 1'b0;
    repeat (3) tick();
    chk_quiet("reset");
    chk("reset_busy2", busy2, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single job on both instances; extra starts at cycles 10 and 39 are ignored
    base = cyc;
    push_job1(base, 1000);
    push_job2(base);
    start  = 1'b1;
    start2 = 1'b1;
    tick();
    start  = 1'b0;
    start2 = 1'b0;
    wait_to(base + 10);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_to(base + 39);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_to(base + 41);
    chk("job1_busy_after_done", busy, 0);
    chk("job1_tile_idx_after", tile_idx, 4);
    chk("job1_perf", perf_cycles, PERF_EXP);
    wait_empty(200);
    repeat (10) tick();

    // Reset asserted mid-job at cycle 20 for two cycles
    base = cyc;
    push_job1(base, 20);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_to(base + 20);
    rst_n = 1'b0;
    #1;
    chk_quiet("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (30) tick();
    chk("reset_events_outstanding", pending(), 0);

    // Fresh job with start held high: reruns the first job, then back-to-back
    base = cyc;
    push_job1(base, 1000);
    push_job1(base + 41, 1000);
    start = 1'b1;
    wait_to(base + 41);
    chk("b2b_gap_busy", busy, 0);
    chk("b2b_gap_perf", perf_cycles, PERF_EXP);
    tick();
    start = 1'b0;
    wait_to(base + 82);
    chk("b2b_busy_after_done", busy, 0);
    chk("b2b_perf", perf_cycles, PERF_EXP);
    wait_empty(200);
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog at cycle %0d: got timeout expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
